// File: rtl/harvard_data_ram.sv
// rtl/harvard_data_ram.sv - word-organised data memory for the Harvard MIPS data port
module harvard_data_ram #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          CNT_W       = 16,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic [31:0]      data_address,
    input  logic             data_write,
    input  logic             data_read,
    input  logic [31:0]      data_writedata,
    output logic [31:0]      data_readdata,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [AW-1:0]    load_index,
    input  logic [31:0]      load_data,
    input  logic             err_clear,
    output logic             mem_ready,
    output logic [2:0]       err_flags,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // One past the last byte address; 33 bits so the bound never wraps.
    localparam logic [32:0] ADDR_END = 33'(BASE_ADDR) + 33'(DEPTH_WORDS) * 33'd4;

    logic [0:0]    state;
    logic [AW-1:0] clr_idx;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          ready;
    logic          aligned;
    logic          in_range;
    logic          addr_ok;
    logic [AW-1:0] idx;
    logic          cpu_wr_en;
    logic          rd_valid;
    logic          access;
    logic [2:0]    err_set;

    assign ready     = (state == ST_READY);
    assign mem_ready = ready;

    assign aligned   = (data_address[1:0] == 2'b00);
    assign in_range  = ({1'b0, data_address} >= {1'b0, BASE_ADDR}) &&
                       ({1'b0, data_address} <  ADDR_END);
    assign addr_ok   = aligned && in_range;
    assign idx       = AW'((data_address - BASE_ADDR) >> 2);

    assign cpu_wr_en = ready && clk_enable && data_write && addr_ok;
    assign rd_valid  = ready && data_read && addr_ok;

    // A CPU write cycle blocks the backdoor, whether or not that write is valid.
    assign load_ready = ready && !(clk_enable && data_write);

    assign data_readdata = rd_valid ? mem[idx] : 32'h0;

    // Error sources only count while the CPU is actually clocked and accessing.
    assign access  = ready && clk_enable && (data_read || data_write);
    assign err_set = {access && data_read && data_write,
                      access && !in_range,
                      access && !aligned};

    // Zero-fill sweep: one word per cycle after reset, then stay READY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
        end else if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == AW'(DEPTH_WORDS - 1)) begin
                state <= ST_READY;
            end
        end
    end

    // Single write port: sweep, then CPU write, then backdoor load.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[clr_idx] <= 32'h0;
        end else if (cpu_wr_en) begin
            mem[idx] <= data_writedata;
        end else if (load_valid && load_ready) begin
            mem[load_index] <= load_data;
        end
    end

    // Sticky error flags; a fresh error in the clear cycle survives the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flags <= 3'b000;
        end else if (err_clear) begin
            err_flags <= err_set;
        end else begin
            err_flags <= err_flags | err_set;
        end
    end

    // Saturating counters of valid, clock-enabled reads and writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_valid && clk_enable && (rd_count != {CNT_W{1'b1}})) begin
                rd_count <= rd_count + 1'b1;
            end
            if (cpu_wr_en && (wr_count != {CNT_W{1'b1}})) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

endmodule
